// File: rtl/md5_feeder_if.sv
// Byte-stream input and round-engine output bundle of md5_feeder.
// The master drives bytes and end strobes; the slave (feeder) drives the engine-side signals.
interface md5_feeder_if;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        msg_end_i;
  logic [31:0] msg_o;      // first stream byte of a word in [31:24], fourth in [7:0]
  logic        rdy_o;
  logic        fsm_rst_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output in_data_i, in_valid_i, msg_end_i,
    input  in_ready_o, msg_o, rdy_o, fsm_rst_o, busy_o, done_o
  );

  modport slave (
    input  in_data_i, in_valid_i, msg_end_i,
    output in_ready_o, msg_o, rdy_o, fsm_rst_o, busy_o, done_o
  );
endinterface

// File: rtl/md5_feeder.sv
// md5_feeder: buffers a byte stream into 512-bit blocks, applies MD5 padding/length, issues words in round order.
// Define MD5_FEED_DBUF_EN for ping-pong block buffers so filling overlaps sending.
module md5_feeder #(
  parameter int unsigned LEN_W = 64
) (
  input logic         clk_i,
  input logic         rst_i,
  md5_feeder_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef MD5_FEED_DBUF_EN
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_FIN   = S_DRAIN;
`else
  localparam logic [2:0] S_FIN   = S_DONE;
`endif

  logic [2:0]       state, nxt, after_q, after_c;
  logic [5:0]       idx, round;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic             pad80, send_act, fsm_rst_q, in_ready_q, busy_q, done_q;
  logic             we_c, take_byte_c, blk_full_c, start_c;
  logic [7:0]       wbyte_c;
  logic [3:0]       g_c;
  logic [31:0]      rd_word;

  assign len64 = 64'(len);

`ifdef MD5_FEED_DBUF_EN
  logic        wr_sel, rd_sel, can_start_c;
  logic [31:0] blk [2][16];

  // A new block may start while the previous one issues its last round.
  assign can_start_c = !send_act || (round == 6'd63);

  always_ff @(posedge clk_i) begin
    if (we_c) blk[wr_sel][idx[5:2]][{~idx[1:0], 3'b000} +: 8] <= wbyte_c;
  end
  assign rd_word = blk[rd_sel][g_c];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else if (start_c) begin
      rd_sel <= wr_sel;
      wr_sel <= ~wr_sel;
    end
  end
`else
  logic [31:0] blk [16];

  always_ff @(posedge clk_i) begin
    if (we_c) blk[idx[5:2]][{~idx[1:0], 3'b000} +: 8] <= wbyte_c;
  end
  assign rd_word = blk[g_c];
`endif

  // MD5 message-word schedule g(r).
  always_comb begin
    case (round[5:4])
      2'd0:    g_c = round[3:0];
      2'd1:    g_c = round[3:0] * 4'd5 + 4'd1;
      2'd2:    g_c = round[3:0] * 4'd3 + 4'd5;
      default: g_c = round[3:0] * 4'd7;
    endcase
  end

  always_comb begin
    nxt         = state;
    we_c        = 1'b0;
    wbyte_c     = bus.in_data_i;
    take_byte_c = 1'b0;
    blk_full_c  = 1'b0;
    start_c     = 1'b0;
    after_c     = (state == S_LEN) ? S_FIN : state;
    case (state)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          take_byte_c = 1'b1;
          nxt         = S_FILL;
        end else if (bus.msg_end_i) begin
          nxt = S_PAD;
        end
      end
      S_FILL: begin
        if (bus.in_valid_i) begin
          take_byte_c = 1'b1;
          blk_full_c  = (idx == 6'd63);
        end else if (bus.msg_end_i) begin
          nxt = S_PAD;
        end
      end
      S_PAD: begin
        we_c    = 1'b1;
        wbyte_c = pad80 ? 8'h00 : 8'h80;
        if (idx == 6'd55) nxt = S_LEN;
        else              blk_full_c = (idx == 6'd63);
      end
      S_LEN: begin
        we_c       = 1'b1;
        wbyte_c    = len64[{idx[2:0], 3'b000} +: 8];
        blk_full_c = (idx == 6'd63);
      end
`ifdef MD5_FEED_DBUF_EN
      S_SEND: begin
        if (can_start_c) begin
          start_c = 1'b1;
          nxt     = after_q;
        end
      end
      S_DRAIN: if (send_act && (round == 6'd63)) nxt = S_DONE;
`else
      S_SEND: if (round == 6'd63) nxt = after_q;
`endif
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (take_byte_c) we_c = 1'b1;
    // A completed block is handed to the round sequencer.
    if (blk_full_c) begin
`ifdef MD5_FEED_DBUF_EN
      if (can_start_c) begin
        start_c = 1'b1;
        nxt     = after_c;
      end else begin
        nxt = S_SEND;
      end
`else
      start_c = 1'b1;
      nxt     = S_SEND;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      after_q    <= S_IDLE;
      idx        <= 6'd0;
      round      <= 6'd0;
      len        <= '0;
      pad80      <= 1'b0;
      send_act   <= 1'b0;
      fsm_rst_q  <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= nxt;
      fsm_rst_q  <= (state == S_IDLE) && (nxt != S_IDLE);
      in_ready_q <= (nxt == S_IDLE) || (nxt == S_FILL);
      busy_q     <= (nxt != S_IDLE) && (nxt != S_DONE);
      done_q     <= (nxt == S_DONE);
      if (we_c) idx <= idx + 6'd1;
      if (state == S_IDLE) begin
        len   <= take_byte_c ? LEN_W'(8) : '0;
        pad80 <= 1'b0;
      end else begin
        if (take_byte_c)     len   <= len + LEN_W'(8);
        if (state == S_PAD)  pad80 <= 1'b1;
      end
      if (blk_full_c) after_q <= after_c;
      if (start_c) begin
        send_act <= 1'b1;
        round    <= 6'd0;
      end else if (send_act) begin
        round <= round + 6'd1;
        if (round == 6'd63) send_act <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o = in_ready_q;
  assign bus.rdy_o      = send_act;
  assign bus.msg_o      = send_act ? rd_word : 32'h0;
  assign bus.fsm_rst_o  = rst_i | fsm_rst_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_md5_feeder.sv
// Directed bench for md5_feeder: message vectors with hand-computed block words, plus reset and ordering sequences.
module tb_md5_feeder;

  logic clk;
  logic rst_i;
  md5_feeder_if bus ();

  md5_feeder #(.LEN_W(64)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          len;
    int          gap;
    int          blocks;
    logic [31:0] f_w0;
    logic [31:0] f_w14;
    logic [31:0] l_w0;
    logic [31:0] l_w14;
  } vec_t;

  vec_t vecs [6];

  logic [3:0] g_tab [64] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd1, 4'd6, 4'd11, 4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3, 4'd8, 4'd13, 4'd2, 4'd7, 4'd12,
    4'd5, 4'd8, 4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2,
    4'd0, 4'd7, 4'd14, 4'd5, 4'd12, 4'd3, 4'd10, 4'd1, 4'd8, 4'd15, 4'd6, 4'd13, 4'd4, 4'd11, 4'd2, 4'd9
  };

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          done_cnt, done_cyc, frst_cnt;
  logic [31:0] words [$];
  int          rcyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture engine-side activity between edges.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bus.rdy_o) begin
        words.push_back(bus.msg_o);
        rcyc.push_back(cyc);
      end
      if (bus.done_o) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (bus.fsm_rst_o) frst_cnt = frst_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int sel, input int i);
    string s;
    case (sel)
      1:       s = "abc";
      2:       s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      default: s = "";
    endcase
    if (sel == 0) return 8'(i);
    return s[i];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int   t  = 0;
    logic ok = 1'b0;
    bus.in_data_i  = b;
    bus.in_valid_i = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.in_ready_o;
      t  = t + 1;
    end while (!ok && t < 1000);
    if (!ok) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL byte_accept: in_ready_o stayed 0, required 1");
    end
    next_cycle();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic put_end();
    int   t  = 0;
    logic ok = 1'b0;
    bus.msg_end_i = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.in_ready_o;
      t  = t + 1;
    end while (!ok && t < 1000);
    if (!ok) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL end_accept: in_ready_o stayed 0, required 1");
    end
    next_cycle();
    bus.msg_end_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t    = 0;
    int errs = 0;
    int base;
    words.delete();
    rcyc.delete();
    done_cnt = 0;
    frst_cnt = 0;
    for (int i = 0; i < v.len; i++) begin
      put_byte(msg_byte(v.sel, i));
      repeat (v.gap) next_cycle();
    end
    put_end();
    while (done_cnt == 0 && t < 3000) begin
      next_cycle();
      t = t + 1;
    end
    repeat (5) next_cycle();
    chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, ".fsm_rst_pulses"}, 32'(frst_cnt), 32'd1);
    chk({tag, ".rdy_cycles"}, 32'(words.size()), 32'(64 * v.blocks));
    chk({tag, ".busy_end"}, 32'(bus.busy_o), 32'd0);
    chk({tag, ".ready_end"}, 32'(bus.in_ready_o), 32'd1);
    if (words.size() == 64 * v.blocks) begin
      base = (v.blocks - 1) * 64;
      chk({tag, ".first_w0"}, words[0], v.f_w0);
      chk({tag, ".first_w14"}, words[14], v.f_w14);
      chk({tag, ".last_w0"}, words[base], v.l_w0);
      chk({tag, ".last_w14"}, words[base + 14], v.l_w14);
      chk({tag, ".last_w15"}, words[base + 15], 32'h0);
      chk({tag, ".done_latency"}, 32'(done_cyc - rcyc[base + 63]), 32'd1);
      for (int b = 0; b < v.blocks; b++) begin
        errs = 0;
        for (int r = 0; r < 64; r++) begin
          int gv = int'(g_tab[r]);
          if (words[b * 64 + r] !== words[b * 64 + gv]) errs++;
          if (rcyc[b * 64 + r] != rcyc[b * 64] + r) errs++;
          if (v.sel == 0 && v.len >= 64 && b == 0 &&
              words[r] !== {8'(4 * gv), 8'(4 * gv + 1), 8'(4 * gv + 2), 8'(4 * gv + 3)}) errs++;
        end
        chk({tag, ".round_order"}, 32'(errs), 32'd0);
      end
`ifndef MD5_FEED_DBUF_EN
      if (v.blocks > 1)
        chk({tag, ".block_gap"}, 32'(rcyc[64] - rcyc[63] > 1), 32'd1);
`endif
    end
  endtask

  initial begin
    vecs[0] = '{sel: 1, len: 0,  gap: 0, blocks: 1, f_w0: 32'h80000000, f_w14: 32'h00000000,
                l_w0: 32'h80000000, l_w14: 32'h00000000};
    vecs[1] = '{sel: 1, len: 3,  gap: 1, blocks: 1, f_w0: 32'h61626380, f_w14: 32'h18000000,
                l_w0: 32'h61626380, l_w14: 32'h18000000};
    vecs[2] = '{sel: 2, len: 56, gap: 0, blocks: 2, f_w0: 32'h61626364, f_w14: 32'h80000000,
                l_w0: 32'h00000000, l_w14: 32'hC0010000};
    vecs[3] = '{sel: 0, len: 64, gap: 0, blocks: 2, f_w0: 32'h00010203, f_w14: 32'h38393A3B,
                l_w0: 32'h80000000, l_w14: 32'h00020000};
    vecs[4] = '{sel: 0, len: 55, gap: 0, blocks: 1, f_w0: 32'h00010203, f_w14: 32'hB8010000,
                l_w0: 32'h00010203, l_w14: 32'hB8010000};
    vecs[5] = '{sel: 0, len: 57, gap: 2, blocks: 2, f_w0: 32'h00010203, f_w14: 32'h38800000,
                l_w0: 32'h00000000, l_w14: 32'hC8010000};

    rst_i          = 1'b1;
    bus.in_data_i  = 8'h00;
    bus.in_valid_i = 1'b0;
    bus.msg_end_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("reset.rdy", 32'(bus.rdy_o), 32'd0);
    chk("reset.msg", bus.msg_o, 32'h0);
    chk("reset.fsm_rst", 32'(bus.fsm_rst_o), 32'd1);
    chk("reset.busy", 32'(bus.busy_o), 32'd0);
    chk("reset.done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    next_cycle();
    chk("idle.fsm_rst", 32'(bus.fsm_rst_o), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abandon a message in the middle of issuing its first block.
    words.delete();
    rcyc.delete();
    for (int i = 0; i < 64; i++) put_byte(8'(i));
    chk("full.in_ready_drop", 32'(bus.in_ready_o), 32'd0);
    chk("full.busy", 32'(bus.busy_o), 32'd1);
    begin
      int t = 0;
      while (words.size() < 31 && t < 500) begin
        @(negedge clk);
        #1;
        t = t + 1;
      end
    end
    chk("midrst.rounds_seen", 32'(words.size()), 32'd31);
    if (words.size() >= 31) begin
      chk("midrst.r16_word", words[16], 32'h04050607);
      chk("midrst.r30_word", words[30], 32'h1C1D1E1F);
    end
    rst_i = 1'b1;
    #1;
    chk("midrst.fsm_rst_pass", 32'(bus.fsm_rst_o), 32'd1);
    @(negedge clk);
    chk("midrst.rdy", 32'(bus.rdy_o), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("midrst.busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    next_cycle();
    run_vec(vecs[1], "abc_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
